// File: rtl/pc_lut_pkg.sv
// rtl/pc_lut_pkg.sv - shared widths, state type and default table contents for pc_target_lut
package pc_lut_pkg;

    localparam int D_DEFAULT = 10;
    localparam int A_DEFAULT = 4;

    typedef enum logic {INIT, RUN} lut_state_e;

    localparam int SHIFT          = 2;
    localparam int CORRECT        = 3;
    localparam int END            = 4;
    localparam int LSBSHIFT       = 5;
    localparam int NEXT           = 6;
    localparam int BEGINSHIFTLOOP = 7;
    localparam int LSBXOR         = 8;

    localparam int NUM_DEFAULTS = 11;
    localparam logic [31:0] DEFAULT_TARGETS [NUM_DEFAULTS] = '{
        32'd0, 32'd11, 32'd80, 32'd68, 32'd113, 32'd53,
        32'd56, 32'd59, 32'd77, 32'd20, 32'd95
    };

    // Entries past the listed defaults load as zero.
    function automatic logic [31:0] default_target(input int unsigned idx);
        if (idx < NUM_DEFAULTS) begin
            return DEFAULT_TARGETS[idx];
        end
        return 32'd0;
    endfunction

endpackage

// File: rtl/pc_lut_storage.sv
// rtl/pc_lut_storage.sv - DEPTH x D register file, one write port, one asynchronous read port
module pc_lut_storage #(
    parameter int D = 10,
    parameter int A = 4
) (
    input  logic         clk,
    input  logic         we,
    input  logic [A-1:0] wa,
    input  logic [D-1:0] wd,
    input  logic [A-1:0] ra,
    output logic [D-1:0] rd
);

    localparam int DEPTH = 2 ** A;

    logic [D-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[wa] <= wd;
        end
    end

    assign rd = mem[ra];

endmodule

// File: rtl/pc_target_lut.sv
// rtl/pc_target_lut.sv - writable branch-target table with init sequencer and PC-relative resolve
module pc_target_lut
    import pc_lut_pkg::*;
#(
    parameter int D = D_DEFAULT,
    parameter int A = A_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         rd_en,
    input  logic [A-1:0] rd_addr,
    input  logic         rd_rel,
    input  logic [D-1:0] pc_in,
    output logic [D-1:0] target,
    output logic         target_valid,
    input  logic         wr_en,
    input  logic [A-1:0] wr_addr,
    input  logic [D-1:0] wr_data,
    output logic         ready
);

    lut_state_e   state;
    logic [A-1:0] cnt;

    logic         mem_we;
    logic [A-1:0] mem_wa;
    logic [D-1:0] mem_wd;
    logic [D-1:0] mem_rd;
    logic [31:0]  init_word;
    logic [D-1:0] init_data;
    logic [D-1:0] entry;
    logic [D-1:0] resolved;
    logic         rd_accept;
    logic         wr_accept;

    assign init_word = default_target(32'(cnt));
    assign init_data = init_word[D-1:0];

    assign rd_accept = rd_en && ready;
    assign wr_accept = wr_en && ready;

    // The init sequencer owns the single write port until the table is loaded.
    assign mem_we = (state == INIT) || wr_accept;
    assign mem_wa = (state == INIT) ? cnt : wr_addr;
    assign mem_wd = (state == INIT) ? init_data : wr_data;

    pc_lut_storage #(
        .D (D),
        .A (A)
    ) u_storage (
        .clk (clk),
        .we  (mem_we),
        .wa  (mem_wa),
        .wd  (mem_wd),
        .ra  (rd_addr),
        .rd  (mem_rd)
    );

    // Write-first: a same-cycle write to the read index is seen by the read.
    assign entry    = (wr_accept && (wr_addr == rd_addr)) ? wr_data : mem_rd;
    assign resolved = rd_rel ? (pc_in + entry) : entry;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= INIT;
            cnt          <= '0;
            ready        <= 1'b0;
            target       <= '0;
            target_valid <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    target_valid <= 1'b0;
                    cnt          <= cnt + 1'b1;
                    if (cnt == {A{1'b1}}) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    target_valid <= rd_accept;
                    if (rd_accept) begin
                        target <= resolved;
                    end
                end
                default: begin
                    state <= INIT;
                end
            endcase
        end
    end

endmodule

// File: doc/pc_target_lut.md
Name: pc_target_lut

Overview:
- Parametrised, writable successor to the fixed 16-entry branch-target table.
- Maps a branch-target index from the instruction to a D-bit target.
- Supports absolute targets and PC-relative targets (signed offset added to the current PC, modulo 2^D).
- Table is loaded with package defaults by an init sequencer after reset, can be rewritten at run time, and is read with one-cycle registered latency.

Parameters:
- D, 10, target/PC width in bits.
- A, 4, index width; DEPTH = 2**A entries.

Ports:
- Clk  input  1  clock, rising edge.
- Reset  input  1  asynchronous, active-low reset.
- rd_en  input  1  read request.
- rd_addr  input  A  entry index.
- rd_rel  input  1  0 = absolute target; 1 = PC-relative, entry treated as signed D-bit offset.
- pc_in  input  D  current PC, sampled with rd_en.
- target  output  D  resolved branch target.
- target_valid  output  1  target valid; single-cycle pulse per accepted read.
- wr_en  input  1  table write request.
- wr_addr  input  A  write index.
- wr_data  input  D  write value.
- ready  output  1  table initialised; reads and writes accepted.

Behaviour:
- Reset (Reset=0, async):
  - state=INIT, init counter=0.
  - target=0, target_valid=0, ready=0.
  - Table contents are don't-care until INIT completes.
- INIT state:
  - Starts on the first Clk edge after Reset deasserts.
  - Each cycle writes entry[cnt] = DEFAULT_TARGETS[cnt], then cnt++.
  - Entries beyond the package list are written 0.
  - After entry DEPTH-1 is written, go to RUN; ready=1 from the next cycle.
  - INIT lasts exactly DEPTH cycles.
  - rd_en and wr_en are ignored during INIT; target_valid stays 0.
- RUN state:
  - Read accepted when rd_en=1 and ready=1.
  - On the next edge: target and target_valid=1 are registered (latency 1).
  - Absolute read: target = entry[rd_addr].
  - Relative read: target = (pc_in + entry[rd_addr]) mod 2^D. Plain D-bit add, carry discarded, so wrap-around in both directions is intended.
  - target holds its last value when no read is accepted; target_valid=0 on those cycles.
  - Write: entry[wr_addr] = wr_data on the edge where wr_en=1 and ready=1.
- Simultaneous read and write, same address in the same cycle: the read returns wr_data (write-first bypass), with the relative add applied to wr_data.
- Simultaneous read and write, different addresses: both complete independently.
- Back-to-back reads: one result per cycle, no bubbles.
- Reset asserted mid-INIT or mid-RUN:
  - Immediate return to reset values.
  - INIT restarts from entry 0; any run-time writes are lost.
- Out-of-range index cannot occur: the index width exactly covers DEPTH.

Decomposition:
- Shared package pc_lut_pkg holds:
  - Default widths (D=10, A=4).
  - State enum {INIT, RUN}.
  - DEFAULT_TARGETS array: 0, 11, 80, 68, 113, 53, 56, 59, 77, 20, 95, remaining 0.
  - Named index constants: SHIFT=2, CORRECT=3, END=4, LSBSHIFT=5, NEXT=6, BEGINSHIFTLOOP=7, LSBXOR=8.
- One natural sub-module, pc_lut_storage: DEPTH x D register file with one write port and one asynchronous read port. The top level holds the init FSM, the bypass mux, the relative adder and the output registers.

Test Plan:
- Reset release, A=4 -> ready=0 for 16 cycles, then 1. Absolute read of idx 2 -> target=80, target_valid=1 exactly one cycle after rd_en.
- Absolute reads of idx 0..10 back to back -> 0, 11, 80, 68, 113, 53, 56, 59, 77, 20, 95 on consecutive cycles; idx 15 -> 0.
- Write idx 12 = 0x3FB (-5), then relative read with pc_in=4 -> target=0x3FF (-1). Relative read of idx 9 (20) with pc_in=1020 -> target=16 (wrap).
- Same-cycle wr_en idx 3 = 200 and rd_en idx 3, absolute -> target=200; the following read of idx 3 -> 200.
- rd_en and wr_en pulsed during INIT -> target_valid stays 0; after ready, a read of the written index returns its default.
- Reset pulsed low mid-RUN after writing idx 1 = 500 -> outputs go to 0 asynchronously, INIT repeats for 16 cycles, and a read of idx 1 returns 11.
